y86_dmem_responder: RTL and testbench

//  Responder end of the memory-stage data interface: accepts one 8-byte read or write request
//  at a time from the Y86 core, performs it on a byte-addressed little-endian array after a fixed

---
 rtl/y86_pkg.sv | 37 +++
 rtl/y86_dmem_array.sv | 33 +++
 rtl/y86_dmem_responder.sv | 107 ++++++++++
 tb/tb_y86_dmem_responder.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/y86_pkg.sv
// Shared Y86 definitions for the data-memory responder: word sizes, status codes,
// FSM state encoding and the request/response record types.
package y86_pkg;

  localparam int WORD_W = 64;
  localparam int BYTE_W = 8;

  typedef enum logic [1:0] {
    AOK = 2'd0,
    HLT = 2'd1,
    ADR = 2'd2,
    INS = 2'd3
  } y86_stat_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  typedef struct packed {
    logic              write;
    logic [WORD_W-1:0] addr;
    logic [WORD_W-1:0] wdata;
  } dmem_req_t;

  typedef struct packed {
    logic [WORD_W-1:0] rdata;
    logic              error;
  } dmem_rsp_t;

  // A memory error from the data port maps onto the core's ADR status.
  function automatic y86_stat_e dmem_status(input logic error);
    return error ? ADR : AOK;
  endfunction

endpackage

// File: rtl/y86_dmem_array.sv
// Byte-addressed little-endian storage with an 8-byte combinational read port
// and an 8-byte synchronous write port. Contents are never cleared by reset.
module y86_dmem_array
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  localparam int AW = $clog2(MEM_BYTES)
) (
  input  logic              clk,
  input  logic              we,
  input  logic [AW-1:0]     addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [BYTE_W-1:0] mem [MEM_BYTES];

  always_comb begin
    rdata = '0;
    for (int i = 0; i < 8; i++) begin
      rdata[i*BYTE_W +: BYTE_W] = mem[addr + AW'(i)];
    end
  end

  always_ff @(posedge clk) begin
    if (we) begin
      for (int i = 0; i < 8; i++) begin
        mem[addr + AW'(i)] <= wdata[i*BYTE_W +: BYTE_W];
      end
    end
  end

endmodule

// File: rtl/y86_dmem_responder.sv
// Memory-stage data responder: one outstanding 8-byte access, fixed latency, ADR error flag.
// Define Y86_DMEM_ALIGN_CHECK_EN to also flag addresses that are not 8-byte aligned.
module y86_dmem_responder
  import y86_pkg::*;
#(
  parameter int MEM_BYTES = 1024,
  parameter int LATENCY   = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [WORD_W-1:0] rsp_rdata,
  output logic              rsp_error
);

  localparam int                AW        = $clog2(MEM_BYTES);
  localparam logic [WORD_W-1:0] LAST_ADDR = WORD_W'(MEM_BYTES - 8);
  localparam logic [3:0]        CNT_LOAD  = 4'(LATENCY - 1);

  dmem_state_e       state, state_next;
  logic [3:0]        cnt;
  dmem_req_t         req_q, acc;
  dmem_rsp_t         rsp_q;
  logic              accept, do_access, acc_err;
  logic [WORD_W-1:0] arr_rdata;

  assign accept = req_valid && req_ready;

  // With a single-cycle latency the access happens on the accepting edge, so it
  // must use the live request rather than the not-yet-captured copy.
  always_comb begin
    acc       = req_q;
    do_access = 1'b0;
    if (LATENCY == 1) begin
      acc       = '{write: req_write, addr: req_addr, wdata: req_wdata};
      do_access = accept;
    end else begin
      do_access = (state == WAIT) && (cnt <= 4'd1);
    end
  end

`ifdef Y86_DMEM_ALIGN_CHECK_EN
  assign acc_err = (acc.addr > LAST_ADDR) || (acc.addr[2:0] != 3'd0);
`else
  assign acc_err = (acc.addr > LAST_ADDR);
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = (LATENCY == 1) ? RESP : WAIT;
      WAIT:    if (do_access) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE);
    rsp_valid = (state == RESP);
    rsp_rdata = rsp_q.rdata;
    rsp_error = rsp_q.error;
  end

  // Response registers only change on the access edge, so they hold through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      req_q <= '0;
      rsp_q <= '0;
    end else begin
      if (accept) begin
        req_q <= '{write: req_write, addr: req_addr, wdata: req_wdata};
        cnt   <= CNT_LOAD;
      end else if (state == WAIT && cnt != 4'd0) begin
        cnt <= cnt - 4'd1;
      end
      if (do_access) begin
        rsp_q.rdata <= (acc.write || acc_err) ? '0 : arr_rdata;
        rsp_q.error <= acc_err;
      end
    end
  end

  y86_dmem_array #(.MEM_BYTES(MEM_BYTES)) u_array (
    .clk   (clk),
    .we    (do_access && acc.write && !acc_err),
    .addr  (acc.addr[AW-1:0]),
    .wdata (acc.wdata),
    .rdata (arr_rdata)
  );

endmodule

// File: tb/tb_y86_dmem_responder.sv
// Self-checking bench for y86_dmem_responder: randomized accesses against a byte-array
// model, plus latency, backpressure, reset-abort and boundary scenarios.
module tb_y86_dmem_responder;

  localparam int MEM_BYTES = 1024;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0, req_write = 1'b0, rsp_ready = 1'b0;
  logic [63:0] req_addr = '0, req_wdata = '0;
  logic        req_ready, rsp_valid, rsp_error;
  logic [63:0] rsp_rdata;

  logic        l1_req_valid = 1'b0, l1_req_write = 1'b0, l1_rsp_ready = 1'b0;
  logic [63:0] l1_req_addr = '0, l1_req_wdata = '0;
  logic        l1_req_ready, l1_rsp_valid, l1_rsp_error;
  logic [63:0] l1_rsp_rdata;

  int n_cmp = 0;
  int n_fail = 0;

  logic [7:0] ref_mem [MEM_BYTES];

  always #5 clk = ~clk;

  y86_dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_rdata(rsp_rdata), .rsp_error(rsp_error)
  );

  y86_dmem_responder #(.MEM_BYTES(MEM_BYTES), .LATENCY(1)) dut_l1 (
    .clk(clk), .rst_n(rst_n),
    .req_valid(l1_req_valid), .req_ready(l1_req_ready), .req_write(l1_req_write),
    .req_addr(l1_req_addr), .req_wdata(l1_req_wdata),
    .rsp_valid(l1_rsp_valid), .rsp_ready(l1_rsp_ready),
    .rsp_rdata(l1_rsp_rdata), .rsp_error(l1_rsp_error)
  );

  // Reference: out-of-range (or misaligned when enabled) accesses touch nothing and read 0.
  task automatic model_access(input logic w, input logic [63:0] a, input logic [63:0] d,
                              output logic [63:0] rd, output logic er);
    er = (a > 64'(MEM_BYTES - 8));
`ifdef Y86_DMEM_ALIGN_CHECK_EN
    if (a % 8 != 0) er = 1'b1;
`endif
    rd = '0;
    if (!er) begin
      for (int i = 0; i < 8; i++) begin
        if (w) ref_mem[int'(a) + i] = d[8*i +: 8];
        else   rd[8*i +: 8] = ref_mem[int'(a) + i];
      end
    end
  endtask

  task automatic do_req(input logic w, input logic [63:0] a, input logic [63:0] d,
                        output logic [63:0] rd, output logic er, output int lat);
    int n;
    rd = 'x; er = 1'bx; lat = 0; n = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d;
    while (!req_ready && n < 50) begin @(negedge clk); n++; end
    if (!req_ready) begin
      n_cmp++; n_fail++; req_valid = 1'b0;
      $display("[TB] FAIL req_timeout: req_ready=%0b required 1", req_ready);
      return;
    end
    @(negedge clk);
    req_valid = 1'b0; lat = 1;
    while (!rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    if (!rsp_valid) begin
      n_cmp++; n_fail++;
      $display("[TB] FAIL rsp_timeout: rsp_valid=%0b required 1", rsp_valid);
      return;
    end
    rd = rsp_rdata; er = rsp_error;
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
  endtask

  task automatic test_reset();
    n_cmp += 4;
    if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_req_ready: got %0b want 1", req_ready); end
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_valid: got %0b want 0", rsp_valid); end
    if (rsp_rdata !== 64'h0) begin n_fail++; $display("[TB] FAIL reset_rsp_rdata: got %h want 0", rsp_rdata); end
    if (rsp_error !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_rsp_error: got %0b want 0", rsp_error); end
  endtask

  task automatic init_memory();
    logic [63:0] erd, rd, d;
    logic        eer, er;
    int          lat;
    for (int a = 0; a < MEM_BYTES; a += 8) begin
      d = {$urandom(), $urandom()};
      model_access(1'b1, 64'(a), d, erd, eer);
      do_req(1'b1, 64'(a), d, rd, er, lat);
    end
  endtask

  task automatic test_write_read();
    logic [63:0] erd, rd;
    logic        eer, er;
    int          lat;
    model_access(1'b1, 64'd16, 64'h0123_4567_89AB_CDEF, erd, eer);
    do_req(1'b1, 64'd16, 64'h0123_4567_89AB_CDEF, rd, er, lat);
    n_cmp += 2;
    if (rd !== 64'h0) begin n_fail++; $display("[TB] FAIL wr_rdata: got %h want 0", rd); end
    if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL wr_error: got %0b want 0", er); end
    do_req(1'b0, 64'd16, 64'h0, rd, er, lat);
    n_cmp += 3;
    if (rd !== 64'h0123_4567_89AB_CDEF) begin n_fail++; $display("[TB] FAIL rd16_rdata: got %h want 0123456789abcdef", rd); end
    if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL rd16_error: got %0b want 0", er); end
    if (lat != 2) begin n_fail++; $display("[TB] FAIL latency2: got %0d want 2", lat); end
  endtask

  task automatic test_range();
    logic [63:0] addrs [4];
    logic [63:0] erd, rd;
    logic        eer, er;
    int          lat;
    addrs[0] = 64'(MEM_BYTES - 8);
    addrs[1] = 64'(MEM_BYTES - 7);
    addrs[2] = 64'hFFFF_FFFF_FFFF_FFFC;
    addrs[3] = 64'h0000_0001_0000_0000;
    for (int i = 0; i < 4; i++) begin
      model_access(1'b0, addrs[i], 64'h0, erd, eer);
      do_req(1'b0, addrs[i], 64'h0, rd, er, lat);
      n_cmp += 2;
      if (er !== eer) begin n_fail++; $display("[TB] FAIL range_error[%0d]: got %0b want %0b", i, er, eer); end
      if (rd !== erd) begin n_fail++; $display("[TB] FAIL range_rdata[%0d]: got %h want %h", i, rd, erd); end
    end
    n_cmp += 2;
    if (eer !== 1'b1) begin n_fail++; $display("[TB] FAIL range_high: model error %0b want 1", eer); end
    do_req(1'b1, 64'(MEM_BYTES - 7), 64'hDEAD_BEEF_DEAD_BEEF, rd, er, lat);
    if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL range_wr_error: got %0b want 1", er); end
    model_access(1'b0, 64'(MEM_BYTES - 8), 64'h0, erd, eer);
    do_req(1'b0, 64'(MEM_BYTES - 8), 64'h0, rd, er, lat);
    n_cmp++;
    if (rd !== erd) begin n_fail++; $display("[TB] FAIL range_wr_untouched: got %h want %h", rd, erd); end
  endtask

  task automatic test_latency_one();
    int lat;
    @(negedge clk);
    l1_req_valid = 1'b1; l1_req_write = 1'b0; l1_req_addr = 64'hFFFF_FFFF_FFFF_FFFC;
    @(negedge clk);
    l1_req_valid = 1'b0; lat = 1;
    while (!l1_rsp_valid && lat < 50) begin @(negedge clk); lat++; end
    n_cmp += 3;
    if (lat != 1) begin n_fail++; $display("[TB] FAIL latency1: got %0d want 1", lat); end
    if (l1_rsp_error !== 1'b1) begin n_fail++; $display("[TB] FAIL l1_error: got %0b want 1", l1_rsp_error); end
    if (l1_rsp_rdata !== 64'h0) begin n_fail++; $display("[TB] FAIL l1_rdata: got %h want 0", l1_rsp_rdata); end
    l1_rsp_ready = 1'b1;
    @(negedge clk);
    l1_rsp_ready = 1'b0;
  endtask

  task automatic test_backpressure();
    logic [63:0] erd, erd8, rd;
    logic        eer, eer8, er;
    int          n;
    model_access(1'b0, 64'd40, 64'h0, erd, eer);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_addr = 64'd40;
    @(negedge clk);
    req_valid = 1'b0; n = 0;
    while (!rsp_valid && n < 50) begin @(negedge clk); n++; end
    for (int c = 0; c < 5; c++) begin
      req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd8; req_wdata = 64'h5555_AAAA_5555_AAAA;
      n_cmp += 4;
      if (rsp_valid !== 1'b1) begin n_fail++; $display("[TB] FAIL bp_valid[%0d]: got %0b want 1", c, rsp_valid); end
      if (rsp_rdata !== erd) begin n_fail++; $display("[TB] FAIL bp_rdata[%0d]: got %h want %h", c, rsp_rdata, erd); end
      if (rsp_error !== eer) begin n_fail++; $display("[TB] FAIL bp_error[%0d]: got %0b want %0b", c, rsp_error, eer); end
      if (req_ready !== 1'b0) begin n_fail++; $display("[TB] FAIL bp_req_ready[%0d]: got %0b want 0", c, req_ready); end
      @(negedge clk);
    end
    req_valid = 1'b0; rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    model_access(1'b0, 64'd8, 64'h0, erd8, eer8);
    do_req(1'b0, 64'd8, 64'h0, rd, er, n);
    n_cmp++;
    if (rd !== erd8) begin n_fail++; $display("[TB] FAIL bp_ignored_req: got %h want %h", rd, erd8); end
  endtask

  task automatic test_reset_mid();
    logic [63:0] erd, rd;
    logic        eer, er;
    int          lat;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_addr = 64'd32; req_wdata = 64'hCAFE_F00D_1234_5678;
    @(negedge clk);
    req_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    n_cmp += 2;
    if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid: got %0b want 0", rsp_valid); end
    if (req_ready !== 1'b1) begin n_fail++; $display("[TB] FAIL rstmid_ready: got %0b want 1", req_ready); end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      n_cmp++;
      if (rsp_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_no_rsp[%0d]: got %0b want 0", c, rsp_valid); end
    end
    model_access(1'b0, 64'd32, 64'h0, erd, eer);
    do_req(1'b0, 64'd32, 64'h0, rd, er, lat);
    n_cmp++;
    if (rd !== erd) begin n_fail++; $display("[TB] FAIL rstmid_contents: got %h want %h", rd, erd); end
  endtask

  task automatic test_unaligned();
    logic [63:0] erd, rd;
    logic        eer, er;
    int          lat;
    model_access(1'b0, 64'd3, 64'h0, erd, eer);
    do_req(1'b0, 64'd3, 64'h0, rd, er, lat);
    n_cmp += 2;
`ifdef Y86_DMEM_ALIGN_CHECK_EN
    if (er !== 1'b1) begin n_fail++; $display("[TB] FAIL unaligned_error: got %0b want 1", er); end
    if (rd !== 64'h0) begin n_fail++; $display("[TB] FAIL unaligned_rdata: got %h want 0", rd); end
`else
    if (er !== 1'b0) begin n_fail++; $display("[TB] FAIL unaligned_error: got %0b want 0", er); end
    if (rd !== {ref_mem[10], ref_mem[9], ref_mem[8], ref_mem[7], ref_mem[6], ref_mem[5], ref_mem[4], ref_mem[3]}) begin
      n_fail++; $display("[TB] FAIL unaligned_rdata: got %h want %h", rd, erd);
    end
`endif
  endtask

  task automatic test_random();
    logic [63:0] a, d, erd, rd;
    logic        w, eer, er;
    int          lat, pick;
    for (int k = 0; k < 60; k++) begin
      w = 1'($urandom_range(0, 1));
      d = {$urandom(), $urandom()};
      pick = $urandom_range(0, 9);
      if (pick < 7)       a = 64'($urandom_range(0, MEM_BYTES - 1));
      else if (pick < 9)  a = 64'($urandom_range(MEM_BYTES - 12, MEM_BYTES + 4));
      else                a = {$urandom(), $urandom()};
      model_access(w, a, d, erd, eer);
      do_req(w, a, d, rd, er, lat);
      n_cmp += 2;
      if (rd !== erd) begin n_fail++; $display("[TB] FAIL rand_rdata[%0d] addr=%h w=%0b: got %h want %h", k, a, w, rd, erd); end
      if (er !== eer) begin n_fail++; $display("[TB] FAIL rand_error[%0d] addr=%h: got %0b want %0b", k, a, er, eer); end
    end
  endtask

  initial begin
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    @(negedge clk);
    init_memory();
    test_write_read();
    test_range();
    test_latency_one();
    test_backpressure();
    test_reset_mid();
    test_unaligned();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
